// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle sequencing controller and the RV32I datapath.
// master = controller side, slave = datapath/board side.
interface multicycle_controller_if;
  logic        Run;
  logic        Step;
  logic [31:0] Instr;
  logic        Zero;
  logic        PCEn;
  logic        RegWrite;
  logic        MemWrite;
  logic        ALUSrc;
  logic        ResultSrc;
  logic        PCSrc;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;
  logic        Busy;
  logic        Halted;
  logic        IllegalInstr;
  logic [31:0] RetireCount;

  modport master (
    input  Run, Step, Instr, Zero,
    output PCEn, RegWrite, MemWrite, ALUSrc, ResultSrc, PCSrc, ImmSrc, ALUControl,
    output Busy, Halted, IllegalInstr, RetireCount
  );

  modport slave (
    output Run, Step, Instr, Zero,
    input  PCEn, RegWrite, MemWrite, ALUSrc, ResultSrc, PCSrc, ImmSrc, ALUControl,
    input  Busy, Halted, IllegalInstr, RetireCount
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset datapath,
// with run/step/halt debug control and a retired-instruction counter.
module multicycle_controller (
  input  logic                    CLK,
  input  logic                    RESET,
  multicycle_controller_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0]  OP_R   = 7'b0110011;
  localparam logic [6:0]  OP_I   = 7'b0010011;
  localparam logic [6:0]  OP_LW  = 7'b0000011;
  localparam logic [6:0]  OP_SW  = 7'b0100011;
  localparam logic [6:0]  OP_BEQ = 7'b1100011;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  function automatic logic f_legal(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    case (instr[6:0])
      OP_R, OP_I:    f_legal = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
      OP_LW, OP_SW:  f_legal = (f3 == 3'b010);
      OP_BEQ:        f_legal = (f3 == 3'b000);
      default:       f_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] f_alu_ctrl(input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7b5);
    f_alu_ctrl = 3'b000;
    if (op == OP_BEQ) begin
      f_alu_ctrl = 3'b001;
    end else if (op == OP_R || op == OP_I) begin
      case (f3)
        3'b000:  f_alu_ctrl = (op == OP_R && f7b5) ? 3'b001 : 3'b000;
        3'b010:  f_alu_ctrl = 3'b101;
        3'b110:  f_alu_ctrl = 3'b011;
        3'b111:  f_alu_ctrl = 3'b010;
        default: f_alu_ctrl = 3'b000;
      endcase
    end
  endfunction

  logic [2:0]  r_state;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic        r_funct7b5;
  logic        r_halted;
  logic        r_illegal;
  logic [31:0] r_retire;

  logic [2:0]  w_next;
  logic [2:0]  w_after;
  logic        w_legal;
  logic        w_is_i;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_is_beq;
  logic        w_pcen;

  assign w_legal  = f_legal(bus.Instr);
  assign w_is_i   = (r_opcode == OP_I);
  assign w_is_lw  = (r_opcode == OP_LW);
  assign w_is_sw  = (r_opcode == OP_SW);
  assign w_is_beq = (r_opcode == OP_BEQ);
  assign w_after  = bus.Run ? S_FETCH : S_IDLE;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.Run || bus.Step) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (w_is_beq)                w_next = w_after;
        else if (w_is_lw || w_is_sw) w_next = S_MEM;
        else                         w_next = S_WB;
      end
      S_MEM:    w_next = w_is_lw ? S_WB : w_after;
      S_WB:     w_next = w_after;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Strobes depend only on registered state and latched fields; RESET masks them at once.
  assign w_pcen = !RESET && ((r_state == S_WB) ||
                             (r_state == S_MEM  && w_is_sw) ||
                             (r_state == S_EXEC && w_is_beq));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_opcode   <= 7'd0;
      r_funct3   <= 3'd0;
      r_funct7b5 <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
      r_retire   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode   <= bus.Instr[6:0];
        r_funct3   <= bus.Instr[14:12];
        r_funct7b5 <= bus.Instr[30];
        if (!w_legal) begin
          r_halted  <= 1'b1;
          r_illegal <= (bus.Instr != ECALL);
        end
      end
      if (w_pcen) r_retire <= r_retire + 32'd1;
    end
  end

  assign bus.PCEn         = w_pcen;
  assign bus.RegWrite     = !RESET && (r_state == S_WB);
  assign bus.MemWrite     = !RESET && (r_state == S_MEM) && w_is_sw;
  assign bus.ALUSrc       = w_is_i || w_is_lw || w_is_sw;
  assign bus.ResultSrc    = w_is_lw;
  assign bus.PCSrc        = (r_state == S_EXEC) && w_is_beq && bus.Zero;
  assign bus.ImmSrc       = w_is_sw ? 2'b01 : (w_is_beq ? 2'b10 : 2'b00);
  assign bus.ALUControl   = f_alu_ctrl(r_opcode, r_funct3, r_funct7b5);
  assign bus.Busy         = (r_state != S_IDLE) && (r_state != S_HALT);
  assign bus.Halted       = r_halted;
  assign bus.IllegalInstr = r_illegal;
  assign bus.RetireCount  = r_retire;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus random legal instruction
// streams, checked against an instruction-level model of latency, strobes and decode.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  multicycle_controller_if bus();

  multicycle_controller dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_retire;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ECALL = 5, K_ILL = 6;

  function automatic int ref_kind(input logic [31:0] w);
    logic ok3;
    ok3 = w[14:12] inside {3'b000, 3'b010, 3'b110, 3'b111};
    if (w == 32'h0000_0073) return K_ECALL;
    case (w[6:0])
      7'b0110011: return ok3 ? K_R : K_ILL;
      7'b0010011: return ok3 ? K_I : K_ILL;
      7'b0000011: return (w[14:12] == 3'b010) ? K_LW : K_ILL;
      7'b0100011: return (w[14:12] == 3'b010) ? K_SW : K_ILL;
      7'b1100011: return (w[14:12] == 3'b000) ? K_BEQ : K_ILL;
      default:    return K_ILL;
    endcase
  endfunction

  // Cycles from FETCH to the PCEn cycle; halting words stop after DECODE.
  function automatic int ref_latency(input int kind);
    case (kind)
      K_BEQ:   return 3;
      K_LW:    return 5;
      K_R, K_I, K_SW: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [31:0] w);
    int kind;
    kind = ref_kind(w);
    if (kind == K_BEQ) return 3'b001;
    if (kind == K_LW || kind == K_SW) return 3'b000;
    case (w[14:12])
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return (kind == K_R && w[30]) ? 3'b001 : 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    logic [2:0]  f3;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 4);
    case ($urandom_range(0, 3))
      0: f3 = 3'b000;
      1: f3 = 3'b010;
      2: f3 = 3'b110;
      default: f3 = 3'b111;
    endcase
    case (k)
      0: begin
        w[6:0] = 7'b0110011; w[14:12] = f3;
        w[31:25] = (f3 == 3'b000 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      1: begin w[6:0] = 7'b0010011; w[14:12] = f3;     end
      2: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
      3: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
      default: begin w[6:0] = 7'b1100011; w[14:12] = 3'b000; end
    endcase
    return w;
  endfunction

  task automatic do_reset();
    bus.Run = 1'b0; bus.Step = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_retire = 32'd0;
  endtask

  // Starts at a negedge whose next posedge enters FETCH (or IDLE with Run/Step raised here).
  task automatic run_instr(input logic [31:0] w, input logic z, input bit keep_run,
                           input bit step_mode);
    int   kind, lat;
    bit   halts, last;
    kind  = ref_kind(w);
    lat   = ref_latency(kind);
    halts = (kind == K_ECALL) || (kind == K_ILL);
    bus.Instr = w; bus.Zero = z;
    if (step_mode) bus.Step = 1'b1; else bus.Run = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.Step = 1'b0;
        if (!keep_run) bus.Run = 1'b0;
        n_checks++;
        if (bus.RetireCount !== model_retire)
          $display("FAIL retire_start w=%h got %h want %h", w, bus.RetireCount, model_retire);
        else n_pass++;
      end
      if (step_mode && k == 2) bus.Step = 1'b1;
      if (step_mode && k == 3) bus.Step = 1'b0;
      last = (k == lat) && !halts;
      n_checks++;
      if (bus.PCEn !== last) $display("FAIL pcen w=%h k=%0d got %b want %b", w, k, bus.PCEn, last);
      else n_pass++;
      n_checks++;
      if (bus.RegWrite !== (last && kind inside {K_R, K_I, K_LW}))
        $display("FAIL regwrite w=%h k=%0d got %b", w, k, bus.RegWrite);
      else n_pass++;
      n_checks++;
      if (bus.MemWrite !== (last && kind == K_SW))
        $display("FAIL memwrite w=%h k=%0d got %b", w, k, bus.MemWrite);
      else n_pass++;
      n_checks++;
      if (bus.PCSrc !== (last && kind == K_BEQ && z))
        $display("FAIL pcsrc w=%h k=%0d z=%b got %b", w, k, z, bus.PCSrc);
      else n_pass++;
      n_checks++;
      if (bus.Busy !== 1'b1 || bus.Halted !== 1'b0)
        $display("FAIL busy_halted w=%h k=%0d got %b%b want 10", w, k, bus.Busy, bus.Halted);
      else n_pass++;
      if (k >= 3) begin
        n_checks++;
        if (bus.ALUControl !== ref_alu(w))
          $display("FAIL aluctrl w=%h k=%0d got %b want %b", w, k, bus.ALUControl, ref_alu(w));
        else n_pass++;
        n_checks++;
        if (bus.ALUSrc !== (kind inside {K_I, K_LW, K_SW}))
          $display("FAIL alusrc w=%h k=%0d got %b", w, k, bus.ALUSrc);
        else n_pass++;
        if (kind != K_R) begin
          n_checks++;
          if (bus.ImmSrc !== ((kind == K_SW) ? 2'b01 : (kind == K_BEQ) ? 2'b10 : 2'b00))
            $display("FAIL immsrc w=%h k=%0d got %b", w, k, bus.ImmSrc);
          else n_pass++;
        end
      end
      if (last) begin
        n_checks++;
        if (bus.ResultSrc !== (kind == K_LW))
          $display("FAIL resultsrc w=%h got %b want %b", w, bus.ResultSrc, kind == K_LW);
        else n_pass++;
      end
      // Instruction memory output no longer matters once DECODE has latched it.
      if (k == 3) bus.Instr = $urandom;
    end
    bus.Step = 1'b0;
    if (halts) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        n_checks++;
        if (bus.Halted !== 1'b1 || bus.IllegalInstr !== (kind == K_ILL) || bus.Busy !== 1'b0)
          $display("FAIL halt_flags w=%h got H=%b I=%b B=%b want I=%b", w, bus.Halted,
                   bus.IllegalInstr, bus.Busy, kind == K_ILL);
        else n_pass++;
        n_checks++;
        if ({bus.PCEn, bus.RegWrite, bus.MemWrite} !== 3'b000 || bus.RetireCount !== model_retire)
          $display("FAIL halt_quiet w=%h got strobes %b count %h want 000 %h", w,
                   {bus.PCEn, bus.RegWrite, bus.MemWrite}, bus.RetireCount, model_retire);
        else n_pass++;
      end
      bus.Run = 1'b0;
    end else begin
      model_retire = model_retire + 32'd1;
      if (!keep_run) begin
        for (int j = 0; j < (step_mode ? 2 : 1); j++) begin
          @(negedge clk);
          n_checks++;
          if (bus.Busy !== 1'b0 || bus.PCEn !== 1'b0 || bus.RetireCount !== model_retire)
            $display("FAIL idle_after w=%h got busy %b count %h want 0 %h", w, bus.Busy,
                     bus.RetireCount, model_retire);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.Instr = 32'hFFFF_FFFF; bus.Zero = 1'b1;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.PCEn, bus.RegWrite, bus.MemWrite, bus.ALUSrc, bus.ResultSrc, bus.PCSrc, bus.ImmSrc,
         bus.ALUControl, bus.Busy, bus.Halted, bus.IllegalInstr} !== 15'd0 ||
        bus.RetireCount !== 32'd0)
      $display("FAIL reset_outputs got nonzero outputs count %h", bus.RetireCount);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (bus.Busy !== 1'b0) $display("FAIL idle_hold got busy %b want 0", bus.Busy);
    else n_pass++;
  endtask

  task automatic test_addi();
    do_reset();
    run_instr(32'h0050_0093, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_lw_sw();
    do_reset();
    run_instr(32'h0000_2103, 1'b0, 1'b1, 1'b0);
    run_instr(32'h0020_2223, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_beq();
    do_reset();
    run_instr(32'h0000_0463, 1'b1, 1'b0, 1'b0);
    run_instr(32'h0000_0463, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_step();
    do_reset();
    run_instr(32'h4020_81B3, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      w = rand_legal();
      run_instr(w, 1'($urandom_range(0, 1)), (i != 29) && ($urandom_range(0, 3) != 0), 1'b0);
    end
  endtask

  task automatic test_halt();
    logic [31:0] w;
    do_reset();
    run_instr(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    do_reset();
    n_checks++;
    if (bus.Halted !== 1'b0 || bus.IllegalInstr !== 1'b0 || bus.Busy !== 1'b0)
      $display("FAIL reset_clears_halt got H=%b I=%b B=%b", bus.Halted, bus.IllegalInstr, bus.Busy);
    else n_pass++;
    run_instr(32'h0000_0073, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_reset();
      w = rand_legal();
      if (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) w[14:12] = 3'b001;
      else w[6:0] = 7'b1111111;
      run_instr(w, 1'b0, 1'b1, 1'b0);
    end
    do_reset();
    run_instr(32'h0050_0093, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_sw();
    do_reset();
    bus.Instr = 32'h0020_2223; bus.Run = 1'b1;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    n_checks++;
    if (bus.MemWrite !== 1'b1) $display("FAIL sw_mem_reached got %b want 1", bus.MemWrite);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.MemWrite, bus.PCEn, bus.RegWrite} !== 3'b000)
      $display("FAIL reset_masks_strobes got %b want 000", {bus.MemWrite, bus.PCEn, bus.RegWrite});
    else n_pass++;
    bus.Run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.RetireCount !== 32'd0)
      $display("FAIL reset_mid_sw got busy %b count %h want 0 0", bus.Busy, bus.RetireCount);
    else n_pass++;
    model_retire = 32'd0;
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.r_retire = 32'hFFFF_FFFF;
    @(negedge clk); @(negedge clk);
    release dut.r_retire;
    @(negedge clk);
    n_checks++;
    if (bus.RetireCount !== 32'hFFFF_FFFF)
      $display("FAIL preload got %h want ffffffff", bus.RetireCount);
    else n_pass++;
    model_retire = 32'hFFFF_FFFF;
    run_instr(32'h0050_0093, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.RetireCount !== 32'd0) $display("FAIL wrap got %h want 0", bus.RetireCount);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.Run = 1'b0; bus.Step = 1'b0; bus.Instr = 32'd0; bus.Zero = 1'b0;
    model_retire = 32'd0;
    test_reset();
    test_addi();
    test_lw_sw();
    test_beq();
    test_step();
    test_back_to_back();
    test_halt();
    test_reset_mid_sw();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish within bound");
    $fatal(1, "timeout");
  end

endmodule
